// File: rtl/seq_divider_if.sv
// Handshake/result bundle for seq_divider: request side (start, operands) and
// result side (busy, done, quotient, remainder, div_by_zero).
interface seq_divider_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Optional macro DIV_ZERO_FASTPATH_EN: divide-by-zero skips CALC and reports at once.
module seq_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                state_q;
  logic [DIVIDEND_W-1:0] work_q, work_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q, done_q, dbz_q;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;

  logic [DIVISOR_W:0]    r_shift;
  logic                  qbit;

  // work_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_comb begin
    r_shift = {rem_q, work_q[DIVIDEND_W-1]};
    qbit    = 1'b0;
    rem_d   = r_shift[DIVISOR_W-1:0];
    if (r_shift >= {1'b0, divisor_q}) begin
      qbit  = 1'b1;
      rem_d = DIVISOR_W'(r_shift - {1'b0, divisor_q});
    end
    work_d = {work_q[DIVIDEND_W-2:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (bus.start) begin
            work_q      <= bus.dividend;
            divisor_q   <= bus.divisor;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= (bus.divisor == '0);
`ifdef DIV_ZERO_FASTPATH_EN
            if (bus.divisor == '0) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= bus.dividend[DIVISOR_W-1:0];
            end else
`endif
            begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= work_d;
            remainder_q <= rem_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter DIVIDEND_W, default 8, dividend and quotient width in bits.
REQ-002 Parameter DIVISOR_W, default 4, divisor and remainder width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request to begin a division; sampled on the rising edge of clk.
REQ-006 dividend  input  DIVIDEND_W  unsigned dividend; captured when start is accepted.
REQ-007 divisor  input  DIVISOR_W  unsigned divisor; captured when start is accepted.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  one-cycle pulse marking valid results.
REQ-010 quotient  output  DIVIDEND_W  unsigned quotient.
REQ-011 remainder  output  DIVISOR_W  unsigned remainder.
REQ-012 div_by_zero  output  1  high when the captured divisor was zero.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-014 start SHALL be accepted only when busy=0, i.e. in IDLE or DONE; start while busy=1 SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-015 On acceptance, the block SHALL capture dividend and divisor, clear the partial remainder (DIVISOR_W+1 bits), clear quotient, set div_by_zero=(divisor==0), and enter CALC.
REQ-016 CALC SHALL perform restoring division MSB-first, one quotient bit per cycle, for exactly DIVIDEND_W cycles.
REQ-017 Each CALC step: R={R[DIVISOR_W-1:0], next dividend bit}. If R>=divisor, then R=R-divisor and the quotient bit is 1; otherwise the quotient bit is 0.
REQ-018 After the final CALC cycle the FSM SHALL enter DONE for exactly one cycle with done=1 and busy=0, then return to IDLE unless start is accepted in that cycle.
REQ-019 With default widths, done SHALL assert in the 9th cycle after the accepting edge (8 CALC cycles plus 1).
REQ-020 busy SHALL be high in CALC only.
REQ-021 quotient, remainder and div_by_zero SHALL hold their final values from DONE until the next accepted start; intermediate values SHALL NOT be visible on the outputs.
REQ-022 For divisor=0, the result SHALL be quotient all-ones, remainder=dividend[DIVISOR_W-1:0] and div_by_zero=1.
REQ-023 Arithmetic SHALL be unsigned; quotient SHALL be exact for every divisor>=1, because the quotient never exceeds DIVIDEND_W bits.
REQ-024 A start accepted in DONE SHALL begin a new operation on the next cycle, with no dead cycle.

Reset
REQ-025 When rst_n is low, the FSM SHALL go to IDLE immediately; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and all internal registers SHALL clear.
REQ-026 A reset during CALC SHALL abort the operation with no done pulse; the first accepted start after rst_n goes high SHALL run normally.

Configuration
REQ-027 Macro DIV_ZERO_FASTPATH_EN: when defined, an accepted start with divisor=0 SHALL skip CALC and go directly to DONE, so done asserts on the 1st cycle after acceptance with the REQ-022 results.
REQ-028 When DIV_ZERO_FASTPATH_EN is undefined, divisor=0 SHALL take the full CALC latency per REQ-019 and give identical result values.

Verification
REQ-029 dividend=200, divisor=7, start pulse -> done in 9th cycle; quotient=28, remainder=4, div_by_zero=0.
REQ-030 dividend=255, divisor=1 -> quotient=255, remainder=0; then dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-031 dividend=0xA7, divisor=0 -> quotient=0xFF, remainder=7, div_by_zero=1; done in cycle 1 with DIV_ZERO_FASTPATH_EN, cycle 9 without.
REQ-032 Start 100/3, then pulse start with 50/5 at cycle 4 -> second request ignored; result quotient=33, remainder=1.
REQ-033 Drop rst_n at cycle 5 of CALC -> outputs 0 immediately, no done; then 13/4 -> quotient=3, remainder=1.
REQ-034 Hold start high continuously with 9/2 -> back-to-back operations, done every 9 cycles; quotient=4, remainder=1 each time.
